countdown_timer_ctrl: RTL

//  Sequences the game's two-digit BCD countdown (00..99 s) that drives the seven-segment display decoder.

---
 rtl/timer_pkg.sv | 31 +++
 rtl/countdown_timer_ctrl_tick_prescaler.sv | 41 ++++
 rtl/countdown_timer_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the game countdown timer and the
//               seven-segment display decoder: FSM state encodings, BCD
//               limits and the blank-digit code.
//               Ports: none (package).
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

   // Countdown sequencer states, 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Largest legal BCD digit.
   localparam logic [3:0] BCD_MAX   = 4'd9;
   // Digit code the display decoder renders as an unlit digit.
   localparam logic [3:0] BCD_BLANK = 4'hF;

   // Limits a digit to the legal BCD range 0..9.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_timer_ctrl_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides the system clock down to one countdown step.
//               Counts 0..DIV-1 while enabled and flags the terminal count.
//   clk   in  1  system clock
//   reset in  1  synchronous active-high reset, clears the count
//   en    in  1  count enable; the count is held while low
//   clr   in  1  synchronous clear, wins over en
//   tick  out 1  high on the cycle the count equals DIV-1 while enabled
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
   parameter int unsigned DIV = 50_000_000   // must be >= 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] c_TERM = CW'(DIV - 1);

   logic [CW-1:0] count_q;

   // Combinational so that the consuming logic acts on the same edge where
   // the count wraps back to zero.
   assign tick = en && (count_q == c_TERM);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= tick ? '0 : count_q + CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_ctrl
// Description : Two-digit BCD countdown sequencer (00..99 s) for the game.
//               Steps once per TICK_DIV clocks while running, handles
//               start / pause / reload and flags expiry to the game FSM.
//   clk          in  1  system clock
//   reset        in  1  synchronous active-high reset, highest priority
//   start        in  1  pulse: load start value and run (IDLE/DONE) or resume (PAUSE)
//   pause        in  1  pulse: toggle RUN <-> PAUSE, ignored in IDLE/DONE
//   reload       in  1  pulse: load start value and return to IDLE
//   timeLeftTen  out 4  tens digit, BCD 0..9
//   timeLeftOne  out 4  ones digit, BCD 0..9
//   running      out 1  high while in RUN
//   timeUp       out 1  single-cycle pulse when the count reaches 00
//   expired      out 1  high while in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter logic [3:0]  START_TEN = 4'd6,
   parameter logic [3:0]  START_ONE = 4'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       reload,
   output logic [3:0] timeLeftTen,
   output logic [3:0] timeLeftOne,
   output logic       running,
   output logic       timeUp,
   output logic       expired
);

   // Out-of-range start digits are forced to 9 so the display never sees
   // a non-BCD code.
   localparam logic [3:0] c_START_TEN = bcd_clamp(START_TEN);
   localparam logic [3:0] c_START_ONE = bcd_clamp(START_ONE);

   state_e     state_q, state_d;
   logic [3:0] ten_q, ten_d;
   logic [3:0] one_q, one_d;
   logic       timeup_q, timeup_d;
   logic       running_q;
   logic       expired_q;

   logic       w_tick;
   logic       w_presc_en;
   logic       w_presc_clr;

   logic [3:0] w_dec_ten;
   logic [3:0] w_dec_one;
   logic       w_dec_zero;

   // ------------------------------------------------------------------------
   // Step prescaler: runs only in RUN, holds its value through PAUSE.
   // ------------------------------------------------------------------------
   assign w_presc_en = (state_q == ST_RUN);

   tick_prescaler #(
      .DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (w_presc_en),
      .clr   (w_presc_clr),
      .tick  (w_tick)
   );

   // ------------------------------------------------------------------------
   // BCD decrement with a floor at 00: ones borrow from tens, and a count
   // already at 00 (start value 00) stays at 00 instead of wrapping to 99.
   // ------------------------------------------------------------------------
   always_comb begin
      w_dec_ten = ten_q;
      w_dec_one = one_q;
      if (one_q != 4'd0) begin
         w_dec_one = one_q - 4'd1;
      end else if (ten_q != 4'd0) begin
         w_dec_one = BCD_MAX;
         w_dec_ten = ten_q - 4'd1;
      end
      w_dec_zero = (w_dec_ten == 4'd0) && (w_dec_one == 4'd0);
   end

   // ------------------------------------------------------------------------
   // Next-state logic. Priority: reload > start > pause (reset is applied in
   // the register block).
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      ten_d       = ten_q;
      one_d       = one_q;
      timeup_d    = 1'b0;
      w_presc_clr = 1'b0;

      if (reload) begin
         state_d     = ST_IDLE;
         ten_d       = c_START_TEN;
         one_d       = c_START_ONE;
         w_presc_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_d     = ST_RUN;
                  ten_d       = c_START_TEN;
                  one_d       = c_START_ONE;
                  w_presc_clr = 1'b1;
               end
            end
            ST_RUN: begin
               // A step that lands on the prescaler terminal count is
               // applied even when pause arrives in the same cycle.
               if (w_tick) begin
                  ten_d = w_dec_ten;
                  one_d = w_dec_one;
               end
               if (w_tick && w_dec_zero) begin
                  timeup_d = 1'b1;
                  state_d  = ST_DONE;
               end else if (pause) begin
                  // start carries no meaning in RUN, so pause decides.
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               // start and pause together still resume only once.
               if (start || pause) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // State, digit and output registers. Status outputs are decoded from the
   // next state so they line up with state_q.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         ten_q     <= c_START_TEN;
         one_q     <= c_START_ONE;
         timeup_q  <= 1'b0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ten_q     <= ten_d;
         one_q     <= one_d;
         timeup_q  <= timeup_d;
         running_q <= (state_d == ST_RUN);
         expired_q <= (state_d == ST_DONE);
      end
   end

   assign timeLeftTen = ten_q;
   assign timeLeftOne = one_q;
   assign running     = running_q;
   assign timeUp      = timeup_q;
   assign expired     = expired_q;

endmodule
`default_nettype wire
